// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//
// Frame-sequencing controller for the UART receiver. It waits in IDLE for a
// low level on rx_in and then walks the frame bit by bit: the start bit, DATA_W
// data bits, an optional parity bit and the stop bit. Each bit lasts `prescale`
// clock cycles. The oversample index within the current bit is edge_cnt, and the
// data bit index is bit_cnt.
//
// The sampled bit is valid at the check point CP = ps/2+2. At that point the
// controller pulses the enable of the checker or deserializer that owns the
// current bit. At the end of the bit, EB = ps-1, it reads that checker's
// registered error flag and decides where to go next. A frame ends with exactly
// one registered pulse in the first IDLE cycle after it: data_valid or
// frame_drop.
//
// Ports
//   clk          receiver (oversampling) clock
//   rst          synchronous, active-high reset
//   rx_in        serial line, idle high; only observed in IDLE
//   prescale     oversampling ratio, latched at start detection
//   par_en       frame carries a parity bit (sampled at the last data EB)
//   strt_glitch  registered start-check result, 1 = false start
//   par_err      registered parity-check result
//   stp_err      registered stop-check result
//   edge_cnt     oversample index within the current bit
//   bit_cnt      data bit index, 0..DATA_W-1
//   dat_samp_en  data-sampling stage enable (high whenever a frame is active)
//   deser_en     one-cycle deserializer shift pulse
//   strt_chk_en  one-cycle start-check pulse
//   par_chk_en   one-cycle parity-check pulse
//   stp_chk_en   one-cycle stop-check pulse
//   disable_err  clears the checker error flags while idle
//   data_valid   one-cycle frame-accepted pulse
//   frame_drop   one-cycle frame-rejected pulse
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int PRESCALE_W = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  dat_samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  disable_err,
  output logic                  data_valid,
  output logic                  frame_drop
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  logic [2:0]            state_q,      state_d;
  logic [PRESCALE_W-1:0] ps_q,         ps_d;
  logic [PRESCALE_W-1:0] edge_cnt_q,   edge_cnt_d;
  logic [3:0]            bit_cnt_q,    bit_cnt_d;
  logic                  data_valid_q, data_valid_d;
  logic                  frame_drop_q, frame_drop_d;

  logic [PRESCALE_W-1:0] check_pt;
  logic [PRESCALE_W-1:0] end_of_bit;
  logic                  at_cp;
  logic                  at_eb;

  // Both points come from the latched prescale. A prescale change mid-frame
  // therefore cannot stretch or shorten the bit that is in progress.
  assign check_pt   = {1'b0, ps_q[PRESCALE_W-1:1]} + PRESCALE_W'(2);
  assign end_of_bit = ps_q - PRESCALE_W'(1);
  assign at_cp      = (edge_cnt_q == check_pt);
  assign at_eb      = (edge_cnt_q == end_of_bit);

  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves one
    // unassigned would infer a latch.
    state_d      = state_q;
    ps_d         = ps_q;
    edge_cnt_d   = at_eb ? '0 : edge_cnt_q + PRESCALE_W'(1);
    bit_cnt_d    = bit_cnt_q;
    data_valid_d = 1'b0;
    frame_drop_d = 1'b0;

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_in) begin
          // The detection cycle is edge 0 of the start bit.
          state_d    = START;
          edge_cnt_d = PRESCALE_W'(1);
          ps_d       = prescale;
        end
      end
      START: begin
        if (at_eb) begin
          if (strt_glitch) begin
            state_d      = IDLE;
            frame_drop_d = 1'b1;
          end else begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
      end
      DATA: begin
        if (at_eb) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_eb) begin
          if (par_err) begin
            state_d      = IDLE;
            frame_drop_d = 1'b1;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (at_eb) begin
          state_d      = IDLE;
          frame_drop_d = stp_err;
          data_valid_d = !stp_err;
        end
      end
      default: begin
        state_d    = IDLE;
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments. Every register then
    // sees the values from before the edge, whatever order the statements are in.
    if (rst) begin
      state_q      <= IDLE;
      ps_q         <= '0;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      data_valid_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ps_q         <= ps_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      data_valid_q <= data_valid_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign edge_cnt    = edge_cnt_q;
  assign bit_cnt     = bit_cnt_q;
  assign dat_samp_en = (state_q != IDLE);
  assign disable_err = (state_q == IDLE);
  assign strt_chk_en = (state_q == START)  && at_cp;
  assign deser_en    = (state_q == DATA)   && at_cp;
  assign par_chk_en  = (state_q == PARITY) && at_cp;
  assign stp_chk_en  = (state_q == STOP)   && at_cp;
  assign data_valid  = data_valid_q;
  assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Self-checking bench for uart_rx_ctrl. The reference model describes a frame
// by its shape: the offset from the detection cycle, the bit length ps, parity
// on or off, and the outcome (accept, false start, parity error, stop error).
// From that shape it computes the expected outputs for every cycle with plain
// division and modulo. Inputs change on the falling edge, and outputs are
// sampled on the falling edge just before the inputs change.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int PW = 6;
  localparam int DW = 8;

  // Frame outcomes
  localparam int OC_OK   = 0;
  localparam int OC_GLT  = 1;
  localparam int OC_PERR = 2;
  localparam int OC_SERR = 3;

  typedef struct packed {
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          dat_samp_en;
    logic          deser_en;
    logic          strt_chk_en;
    logic          par_chk_en;
    logic          stp_chk_en;
    logic          disable_err;
    logic          data_valid;
    logic          frame_drop;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          par_en;
  logic          strt_glitch;
  logic          par_err;
  logic          stp_err;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          dat_samp_en;
  logic          deser_en;
  logic          strt_chk_en;
  logic          par_chk_en;
  logic          stp_chk_en;
  logic          disable_err;
  logic          data_valid;
  logic          frame_drop;

  int n_checks = 0;
  int n_fail   = 0;
  // Pulse counts seen during the last run_frame call
  int dv_seen, fd_seen, deser_seen;

  uart_rx_ctrl #(.PRESCALE_W(PW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .dat_samp_en (dat_samp_en),
    .deser_en    (deser_en),
    .strt_chk_en (strt_chk_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .disable_err (disable_err),
    .data_valid  (data_valid),
    .frame_drop  (frame_drop)
  );

  always #5 clk = ~clk;

  function automatic obs_t observed();
    obs_t o;
    o = '{edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
          stp_chk_en, disable_err, data_valid, frame_drop};
    return o;
  endfunction

  // Frame length in cycles, measured from the detection cycle to the IDLE
  // cycle that carries the result pulse.
  function automatic int frame_len(int ps, bit par, int oc);
    case (oc)
      OC_GLT:  return ps;
      OC_PERR: return (DW + 2) * ps;
      default: return (DW + 2 + (par ? 1 : 0)) * ps;
    endcase
  endfunction

  // Expected outputs at offset k of a frame. Bit 0 is the start bit, bits
  // 1..DW carry data, then the parity bit if enabled, then the stop bit.
  function automatic obs_t model(int k, int ps, bit par, int oc, int len);
    obs_t e;
    int   b, ed, cp;
    e = '0;
    if (k == 0 || k >= len) begin
      e.disable_err = 1'b1;
      if (k == len) begin
        e.data_valid = (oc == OC_OK);
        e.frame_drop = (oc != OC_OK);
      end
      return e;
    end
    b  = k / ps;
    ed = k % ps;
    cp = ps / 2 + 2;
    e.edge_cnt    = PW'(ed);
    e.dat_samp_en = 1'b1;
    if (b == 0)                      e.strt_chk_en = (ed == cp);
    else if (b <= DW) begin
      e.bit_cnt  = 4'(b - 1);
      e.deser_en = (ed == cp);
    end
    else if (par && b == DW + 1)     e.par_chk_en = (ed == cp);
    else                             e.stp_chk_en = (ed == cp);
    return e;
  endfunction

  // bit_cnt is only defined by the frame rules in IDLE, START and DATA.
  function automatic obs_t mask_at(int k, int ps, int len);
    obs_t m;
    m = '1;
    if (k > 0 && k < len && (k / ps) > DW) m.bit_cnt = '0;
    return m;
  endfunction

  // Runs one frame from its detection cycle through its result cycle.
  //   started : the detection cycle was already driven by the previous frame
  //   b2b     : drive a new start in the result cycle, using next_ps
  //   chg_at  : from this offset on, drive prescale = chg_val (-1 = never)
  //   rst_at  : assert rst in this cycle and end the frame (-1 = never)
  task automatic run_frame(input string name, input int ps, input bit par,
                           input int oc, input bit started, input bit b2b,
                           input int next_ps, input int chg_at, input int chg_val,
                           input int rst_at);
    obs_t exp_v, got, m;
    int   len, par_samp_k;
    len        = frame_len(ps, par, oc);
    par_samp_k = (DW + 1) * ps - 1;
    dv_seen    = 0;
    fd_seen    = 0;
    deser_seen = 0;
    for (int k = (started ? 1 : 0); k <= len; k++) begin
      @(negedge clk);
      got = observed();
      dv_seen    += int'(data_valid);
      fd_seen    += int'(frame_drop);
      deser_seen += int'(deser_en);
      if (rst_at >= 0 && k == rst_at + 1) begin
        exp_v = '0;
        exp_v.disable_err = 1'b1;
        m = '1;
      end else begin
        exp_v = model(k, ps, par, oc, len);
        m     = mask_at(k, ps, len);
      end
      n_checks++;
      if ((got & m) !== (exp_v & m))
        $display("FAIL %s k=%0d got=%h exp=%h", name, k, got & m, exp_v & m);
      if ((got & m) !== (exp_v & m)) n_fail++;
      if (rst_at >= 0 && k == rst_at + 1) begin
        rst   = 1'b0;
        rx_in = 1'b1;
        return;
      end
      // Drive the inputs for cycle k. rx_in is noise while the frame is
      // active, and par_en is noise except in the one cycle where it is sampled.
      rst         = (k == rst_at);
      rx_in       = (k == 0) ? 1'b0 : (k == len) ? !b2b : 1'($urandom);
      par_en      = (k == par_samp_k) ? par : 1'($urandom);
      strt_glitch = (oc == OC_GLT);
      par_err     = (oc == OC_PERR);
      stp_err     = (oc == OC_SERR);
      if (k == len && b2b)                 prescale = PW'(next_ps);
      else if (chg_at >= 0 && k >= chg_at) prescale = PW'(chg_val);
      else                                 prescale = PW'(ps);
    end
  endtask

  // Idle cycles: the line stays high and the controller must stay quiet.
  task automatic idle_cycles(input int n);
    obs_t exp_v;
    exp_v = '0;
    exp_v.disable_err = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if (observed() !== exp_v) begin
        n_fail++;
        $display("FAIL idle i=%0d got=%h exp=%h", i, observed(), exp_v);
      end
      rx_in = 1'b1;
      rst   = 1'b0;
    end
  endtask

  task automatic test_reset();
    obs_t exp_v;
    rst = 1'b1; rx_in = 1'b0; prescale = PW'(8); par_en = 1'b0;
    strt_glitch = 1'b1; par_err = 1'b1; stp_err = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_v = '0;
    exp_v.disable_err = 1'b1;
    n_checks++;
    if (observed() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", observed(), exp_v);
    end
    rst = 1'b0; rx_in = 1'b1;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_clean_frame();
    run_frame("clean_ps8", 8, 1'b0, OC_OK, 1'b0, 1'b0, 8, -1, 0, -1);
    n_checks++;
    if (dv_seen !== 1 || fd_seen !== 0 || deser_seen !== DW) begin
      n_fail++;
      $display("FAIL clean_counts dv=%0d fd=%0d deser=%0d exp 1/0/%0d",
               dv_seen, fd_seen, deser_seen, DW);
    end
    idle_cycles(2);
    run_frame("clean_par_ps8", 8, 1'b1, OC_OK, 1'b0, 1'b0, 8, -1, 0, -1);
    idle_cycles(2);
  endtask

  task automatic test_parity_err();
    run_frame("par_err", 8, 1'b1, OC_PERR, 1'b0, 1'b0, 8, -1, 0, -1);
    n_checks++;
    if (dv_seen !== 0 || fd_seen !== 1) begin
      n_fail++;
      $display("FAIL par_err_counts dv=%0d fd=%0d exp 0/1", dv_seen, fd_seen);
    end
    idle_cycles(3);
  endtask

  task automatic test_start_glitch();
    run_frame("glitch_ps16", 16, 1'b0, OC_GLT, 1'b0, 1'b0, 16, -1, 0, -1);
    n_checks++;
    if (deser_seen !== 0 || fd_seen !== 1 || dv_seen !== 0) begin
      n_fail++;
      $display("FAIL glitch_counts deser=%0d fd=%0d dv=%0d exp 0/1/0",
               deser_seen, fd_seen, dv_seen);
    end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    run_frame("stop_err", 8, 1'b0, OC_SERR, 1'b0, 1'b1, 8, -1, 0, -1);
    run_frame("b2b_second", 8, 1'b0, OC_OK, 1'b1, 1'b0, 8, -1, 0, -1);
    n_checks++;
    if (dv_seen !== 1 || fd_seen !== 0) begin
      n_fail++;
      $display("FAIL b2b_counts dv=%0d fd=%0d exp 1/0", dv_seen, fd_seen);
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_frame();
    run_frame("rst_mid", 8, 1'b0, OC_OK, 1'b0, 1'b0, 8, -1, 0, 40);
    n_checks++;
    if (dv_seen !== 0 || fd_seen !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_counts dv=%0d fd=%0d exp 0/0", dv_seen, fd_seen);
    end
    idle_cycles(4);
  endtask

  task automatic test_prescale_change();
    run_frame("ps_chg_first", 8, 1'b0, OC_OK, 1'b0, 1'b0, 8, 20, 16, -1);
    idle_cycles(2);
    run_frame("ps_chg_second", 16, 1'b0, OC_OK, 1'b0, 1'b0, 16, -1, 0, -1);
    idle_cycles(2);
  endtask

  task automatic test_random();
    int ps_tbl[6] = '{8, 10, 12, 16, 20, 32};
    int ps, nps, oc;
    bit par, b2b, started;
    started = 1'b0;
    ps = 8;
    for (int f = 0; f < 20; f++) begin
      par = 1'($urandom);
      oc  = int'($urandom_range(0, 3));
      if (oc == OC_PERR && !par) oc = OC_SERR;
      b2b = 1'($urandom);
      nps = ps_tbl[$urandom_range(0, 5)];
      run_frame("random", ps, par, oc, started, b2b, nps, -1, 0, -1);
      started = b2b;
      if (!b2b) idle_cycles(int'($urandom_range(1, 3)));
      ps = nps;
    end
    if (started) run_frame("random_tail", ps, 1'b0, OC_OK, 1'b1, 1'b0, ps, -1, 0, -1);
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_parity_err();
    test_start_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_prescale_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
